arbiter_puf_array: RTL and testbench

- Parametrised successor of the single 8-stage arbiter PUF.
- N_CHAINS independent mux delay chains, each C_LENGTH stages, each terminated by an arbiter flop.
- Controller FSM generates the launch pulse itself instead of using clk. It runs N_EVAL repeated evaluations per challenge, synchronises each arbiter bit into clk, and majority-votes per chain.
- Returns an N_CHAINS-bit response plus a per-bit stability flag over a valid/ready handshake; sits behind the tt_um top-level I/O wrapper.

---
 rtl/arbiter_puf_array_if.sv | 34 +++
 rtl/arbiter_puf_array.sv | 175 +++++++++++++++++
 tb/tb_arbiter_puf_array.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_puf_array_if.sv
// Request/response bundle for the arbiter PUF array:
// challenge/start in, voted response out over valid/ready.
interface arbiter_puf_array_if #(
  parameter int C_LENGTH = 8,
  parameter int N_CHAINS = 4
);
  logic [C_LENGTH-1:0] challenge;
  logic                start;
  logic                busy;
  logic [N_CHAINS-1:0] resp;
  logic [N_CHAINS-1:0] resp_stable;
  logic                resp_valid;
  logic                resp_ready;

  modport master (
    output challenge,
    output start,
    output resp_ready,
    input  busy,
    input  resp,
    input  resp_stable,
    input  resp_valid
  );

  modport slave (
    input  challenge,
    input  start,
    input  resp_ready,
    output busy,
    output resp,
    output resp_stable,
    output resp_valid
  );
endinterface

// File: rtl/arbiter_puf_array.sv
// N_CHAINS arbiter PUF delay chains with a launch-pulse
// controller, 2-flop sync and per-chain majority vote.
module arbiter_puf_array #(
  parameter int C_LENGTH      = 8,
  parameter int N_CHAINS      = 4,
  parameter int N_EVAL        = 7,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  arbiter_puf_array_if.slave bus
);

  if (N_CHAINS < 1 || N_CHAINS > 8) begin : g_bad_chains
    $error("N_CHAINS must be 1..8");
  end
  if (N_EVAL < 1 || N_EVAL > 15 || (N_EVAL % 2) == 0)
  begin : g_bad_eval
    $error("N_EVAL must be odd and 1..15");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 3");
  end

  localparam int W  = $clog2(N_EVAL + 1);
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [W-1:0]  NE   = W'(N_EVAL);
  localparam logic [W-1:0]  HALF = W'(N_EVAL / 2);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, LOW, HIGH, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        idx_q, idx_d;
  logic [W-1:0]        ones_q  [N_CHAINS];
  logic [W-1:0]        ones_nx [N_CHAINS];
  logic                launch, launch_d;
  logic                accept, sample, finish;
  logic [C_LENGTH-1:0] ch_q;
  logic [N_CHAINS-1:0] arb_q;
  logic [N_CHAINS-1:0] sync1, sync_q;
  logic [N_CHAINS-1:0] resp_q, stable_q;
  logic                valid_q;

  // Each chain sees the challenge rotated left by its index.
  for (genvar k = 0; k < N_CHAINS; k++) begin : g_ch
    logic arb_bit;
    for (genvar i = 0; i < C_LENGTH; i++) begin : g_st
      localparam int SRC =
        (i + C_LENGTH - (k % C_LENGTH)) % C_LENGTH;
      (* dont_touch = "true" *) logic t;
      (* dont_touch = "true" *) logic b;
      logic ti, bi;
      if (i == 0) begin : g_in
        assign ti = launch;
        assign bi = launch;
      end else begin : g_in
        assign ti = g_st[i-1].t;
        assign bi = g_st[i-1].b;
      end
      assign t = ch_q[SRC] ? bi : ti;
      assign b = ch_q[SRC] ? ti : bi;
      if (i == C_LENGTH - 1) begin : g_arb
        always_ff @(posedge t) arb_bit <= b;
      end
    end
    assign arb_q[k] = arb_bit;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    launch_d = 1'b0;
    accept   = 1'b0;
    sample   = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = LOW;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      LOW: begin
        if (cnt_q == CMAX) begin
          state_d  = HIGH;
          cnt_d    = '0;
          launch_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == CMAX) begin
          sample = 1'b1;
          cnt_d  = '0;
          idx_d  = idx_q + 1'b1;
          if (idx_d == NE) begin
            finish  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LOW;
          end
        end else begin
          launch_d = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < N_CHAINS; k++) begin
      ones_nx[k] = ones_q[k] + W'(sync_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      launch   <= 1'b0;
      sync1    <= '0;
      sync_q   <= '0;
      resp_q   <= '0;
      stable_q <= '0;
      valid_q  <= 1'b0;
      for (int k = 0; k < N_CHAINS; k++) begin
        ones_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      launch  <= launch_d;
      sync1   <= arb_q;
      sync_q  <= sync1;
      if (accept) ch_q <= bus.challenge;
      for (int k = 0; k < N_CHAINS; k++) begin
        if (accept) begin
          ones_q[k] <= '0;
        end else if (sample) begin
          ones_q[k] <= ones_nx[k];
        end
      end
      if (finish) begin
        valid_q <= 1'b1;
        for (int k = 0; k < N_CHAINS; k++) begin
          resp_q[k]   <= (ones_nx[k] > HALF);
          stable_q[k] <= (ones_nx[k] == '0) ||
                         (ones_nx[k] == NE);
        end
      end else if (state_q == DONE && bus.resp_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.resp        = resp_q;
  assign bus.resp_stable = stable_q;
  assign bus.resp_valid  = valid_q;

endmodule

// File: tb/tb_arbiter_puf_array.sv
// Directed bench for arbiter_puf_array: forced arbiter
// outputs, latency, voting, handshake and reset cases.
module tb_arbiter_puf_array;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arbiter_puf_array_if #(.C_LENGTH(8), .N_CHAINS(4)) bus ();
  arbiter_puf_array_if #(.C_LENGTH(16), .N_CHAINS(8)) bus2 ();

  arbiter_puf_array #(
    .C_LENGTH(8), .N_CHAINS(4),
    .N_EVAL(7), .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  arbiter_puf_array #(
    .C_LENGTH(16), .N_CHAINS(8),
    .N_EVAL(1), .SETTLE_CYCLES(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.resp !== 4'b0000) begin
      failures++;
      $display("FAIL reset_resp got=%b exp=0000", bus.resp);
    end
    checks++;
    if (bus.resp_stable !== 4'b0000) begin
      failures++;
      $display("FAIL reset_stable got=%b exp=0000",
               bus.resp_stable);
    end
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0",
               bus.resp_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (dut.launch !== 1'b0) begin
      failures++;
      $display("FAIL reset_launch got=%b exp=0", dut.launch);
    end
    checks++;
    if (bus2.resp_valid !== 1'b0 || bus2.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut2 valid=%b busy=%b exp=0/0",
               bus2.resp_valid, bus2.busy);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d busy=%b valid=%b exp=0/0",
                 i, bus.busy, bus.resp_valid);
      end
    end
  endtask

  task automatic test_unanimous;
    int n, highs, rises;
    logic prev;
    force dut.arb_q = 4'b1010;
    bus.challenge = 8'hA5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.challenge = 8'h00;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL unan_busy got=%b exp=1", bus.busy);
    end
    n = 0;
    highs = 0;
    rises = 0;
    prev = dut.launch;
    while (bus.resp_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (dut.launch && !prev) rises++;
      if (dut.launch) highs++;
      prev = dut.launch;
    end
    checks++;
    if (n != 56) begin
      failures++;
      $display("FAIL unan_latency got=%0d exp=56", n);
    end
    checks++;
    if (rises != 7) begin
      failures++;
      $display("FAIL unan_launch_pulses got=%0d exp=7", rises);
    end
    checks++;
    if (highs != 28) begin
      failures++;
      $display("FAIL unan_launch_high got=%0d exp=28", highs);
    end
    checks++;
    if (bus.resp !== 4'b1010) begin
      failures++;
      $display("FAIL unan_resp got=%b exp=1010", bus.resp);
    end
    checks++;
    if (bus.resp_stable !== 4'b1111) begin
      failures++;
      $display("FAIL unan_stable got=%b exp=1111",
               bus.resp_stable);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL unan_accept valid=%b busy=%b exp=0/0",
               bus.resp_valid, bus.busy);
    end
  endtask

  task automatic test_majority;
    force dut.arb_q = 4'b0001;
    bus.challenge = 8'h3C;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int e = 0; e < 7; e++) begin
      if (e == 2) force dut.arb_q = 4'b0011;
      else if (e < 4) force dut.arb_q = 4'b0001;
      else force dut.arb_q = 4'b0000;
      repeat (8) tick();
    end
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL maj_valid got=%b exp=1", bus.resp_valid);
    end
    checks++;
    if (bus.resp !== 4'b0001) begin
      failures++;
      $display("FAIL maj_resp got=%b exp=0001", bus.resp);
    end
    checks++;
    if (bus.resp_stable !== 4'b1100) begin
      failures++;
      $display("FAIL maj_stable got=%b exp=1100",
               bus.resp_stable);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.busy !== 1'b1 ||
          bus.resp !== 4'b0001 ||
          bus.resp_stable !== 4'b1100) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d v=%b b=%b r=%b s=%b exp=1/1/0001/1100",
                 i, bus.resp_valid, bus.busy, bus.resp,
                 bus.resp_stable);
      end
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept valid=%b busy=%b exp=0/0",
               bus.resp_valid, bus.busy);
    end
    checks++;
    if (bus.resp !== 4'b0001 || bus.resp_stable !== 4'b1100)
    begin
      failures++;
      $display("FAIL bp_resp_kept r=%b s=%b exp=0001/1100",
               bus.resp, bus.resp_stable);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_restart busy=%b exp=1", bus.busy);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    repeat (28) tick();
    checks++;
    if (dut.launch !== 1'b1) begin
      failures++;
      $display("FAIL mid_in_high launch=%b exp=1", dut.launch);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 ||
        dut.launch !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset busy=%b valid=%b launch=%b exp=0/0/0",
               bus.busy, bus.resp_valid, dut.launch);
    end
    checks++;
    if (bus.resp !== 4'b0000 || bus.resp_stable !== 4'b0000)
    begin
      failures++;
      $display("FAIL mid_reset_resp r=%b s=%b exp=0000/0000",
               bus.resp, bus.resp_stable);
    end
    force dut.arb_q = 4'b1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 56) begin
      failures++;
      $display("FAIL mid_latency got=%0d exp=56", n);
    end
    checks++;
    if (bus.resp !== 4'b1111 || bus.resp_stable !== 4'b1111)
    begin
      failures++;
      $display("FAIL mid_resp r=%b s=%b exp=1111/1111",
               bus.resp, bus.resp_stable);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_sweep;
    int n;
    force dut2.arb_q = 8'h3C;
    bus2.challenge = 16'hBEEF;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    n = 0;
    while (bus2.resp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL sweep_latency got=%0d exp=6", n);
    end
    checks++;
    if (bus2.resp !== 8'h3C) begin
      failures++;
      $display("FAIL sweep_resp got=%h exp=3c", bus2.resp);
    end
    checks++;
    if (bus2.resp_stable !== 8'hFF) begin
      failures++;
      $display("FAIL sweep_stable got=%h exp=ff",
               bus2.resp_stable);
    end
    bus2.resp_ready = 1'b1;
    tick();
    bus2.resp_ready = 1'b0;
    checks++;
    if (bus2.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL sweep_accept got=%b exp=0",
               bus2.resp_valid);
    end
  endtask

  initial begin
    bus.challenge   = '0;
    bus.start       = 1'b0;
    bus.resp_ready  = 1'b0;
    bus2.challenge  = '0;
    bus2.start      = 1'b0;
    bus2.resp_ready = 1'b0;
    test_reset();
    test_unanimous();
    test_majority();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
